// File: rtl/register_file.sv
// RISC-V integer register file: 32 x 32-bit, two combinational read ports,
// one synchronous write port, x0 hardwired to zero, asynchronous clear.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     read_reg1,
  input  logic [ADDR_W-1:0]     read_reg2,
  input  logic [ADDR_W-1:0]     write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Entry 0 is forced to zero every cycle, so its flop is constant and never
  // carries a written value.
  always_comb begin
    regs_d = regs_q;
    if (reg_write && (write_reg != '0)) begin
      regs_d[write_reg] = write_data;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // No write bypass: a read of the register being written shows the old
  // value until the edge commits it; forwarding belongs to the pipeline.
  assign read_data1 = (read_reg1 == '0) ? '0 : regs_q[read_reg1];
  assign read_data2 = (read_reg2 == '0) ? '0 : regs_q[read_reg2];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a reference model predicts each read,
// predictions are queued when the read is driven and compared once it settles.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  register_file #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [32];
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Drive both read addresses, queue the prediction, compare after settling.
  task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    read_reg1 = a1;
    read_reg2 = a2;
    exp_q.push_back('{tag: tag, e1: model[a1], e2: model[a2]});
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_rd1"}, read_data1, e.e1);
      chk({e.tag, "_rd2"}, read_data2, e.e2);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic en);
    @(negedge clk);
    write_reg  = a;
    write_data = d;
    reg_write  = en;
    @(posedge clk);
    if (en && (a != 5'd0) && !reset) model[a] = d;
    #1;
    reg_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    clear_model();

    #3;
    read_check("rst_hold", 5'd5, 5'd17);
    #8;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) read_check("rst_sweep", 5'(i), 5'(31 - i));

    do_write(5'd1, 32'd100, 1'b1);
    read_check("basic", 5'd1, 5'd0);
    do_write(5'd2, 32'd200, 1'b1);
    read_check("dual", 5'd2, 5'd1);
    do_write(5'd0, 32'd999, 1'b1);
    read_check("x0", 5'd0, 5'd0);

    @(negedge clk);
    write_reg = 5'd3; write_data = 32'hDEADBEEF; reg_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read_check("gate", 5'd3, 5'd3);

    @(negedge clk);
    reg_write = 1'b1;
    read_check("rdw_pre", 5'd3, 5'd3);
    @(posedge clk);
    model[3] = 32'hDEADBEEF;
    #1;
    reg_write = 1'b0;
    read_check("rdw_post", 5'd3, 5'd0);

    for (int k = 0; k < 40; k++) begin
      do_write(5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 32; i++) read_check("rand_sweep", 5'(i), 5'((i + 7) % 32));

    do_write(5'd1, 32'd100, 1'b1);
    do_write(5'd2, 32'd200, 1'b1);
    @(negedge clk);
    read_check("pre_rst", 5'd1, 5'd2);
    #2;
    reset = 1'b1;
    clear_model();
    read_check("async_rst", 5'd1, 5'd2);

    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    read_check("rst_blk", 5'd5, 5'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    reg_write = 1'b0;
    read_check("post_rst", 5'd5, 5'd2);
    do_write(5'd5, 32'hCAFEF00D, 1'b1);
    read_check("first_wr", 5'd5, 5'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
